mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
// - Pipeline MEM stage: holds the EX/MEM register, runs load/store on data-memory req/ack bus, writes MEM/WB register.
// - Consumes EX results (ALU result = address/value, store data, valid); returns MEM_data for EX forwarding.
// - Stalls the pipeline (MEM_busy) while an access waits for ack; bus timeout guard -> error flag.
// PARAMETERS
// - MEM_TIMEOUT  255  cycles waiting for mem_ack before abort with bus error (1..255)
// PORTS
// - clk              in   1   clock, rising edge
// - rst              in   1   asynchronous reset, active-low (0 = reset)
// - EX_alu_res       in   32  ALU result: address for ld/st, else writeback value
// - EX_mem_din       in   32  store data (rs2, already forwarded)
// - EX_vld           in   1   EX result valid
// - EX_mem_ctrl      in   5   [4]=load [3]=store [2]=unsigned [1:0]=size 00 B,01 H,10 W,11 -> W
// - EX_rd            in   5   destination register
// - EX_wb_en         in   1   writes rd
// - mem_req          out  1   access request, held until ack/abort
// - mem_we           out  1   1 = store
// - mem_addr         out  32  word-aligned address {addr[31:2],2'b00}
// - mem_wdata        out  32  lane-shifted store data
// - mem_be           out  4   byte enables
// - mem_rdata        in   32  load word, valid with mem_ack
// - mem_ack          in   1   access complete (same cycle as req allowed)
// - MEM_data         out  32  EX/MEM ALU result, for forwarding (comb from EX/MEM reg)
// - MEM_busy         out  1   stall: EX/MEM and upstream must hold
// - MEM_WB_data      out  32  registered writeback data
// - MEM_WB_rd        out  5   registered rd
// - MEM_WB_wb_en     out  1   registered write enable (0 if invalid/error)
// - MEM_WB_vld       out  1   registered valid
// - MEM_WB_err       out  1   registered fault (timeout or misaligned)
// BEHAVIOUR
// - Reset: every register and output 0; FSM IDLE; mem_req drops asynchronously on rst=0.
// - EX/MEM reg loads EX_* on clk edge when MEM_busy=0; holds otherwise. EX_vld=0 loads a bubble.
// - FSM IDLE: EX/MEM vld & (load|store) -> mem_req=1 same cycle, go ACCESS unless mem_ack that cycle.
// - ACCESS: req/we/addr/wdata/be stable; ack -> IDLE; counter reaches MEM_TIMEOUT -> abort, IDLE, err.
// - Timeout counter 8b, cleared on every new access; counts cycles with req=1 & ack=0.
// - MEM_busy = mem_req & ~mem_ack & ~abort; zero-wait access (ack with req) -> no stall.
// - Load and store both set => treated as load. Non-memory op: no req, 1-cycle pass-through.
// - Store lanes, a=addr[1:0]: B be=0001<<a, wdata=din[7:0] replicated x4; H be=0011<<{a[1],0},
//   wdata={din[15:0],din[15:0]}; W be=1111, wdata=din.
// - Load extract: B rdata byte a, H half a[1]; sign-extend, zero-extend if unsigned; W raw.
// - MEM_WB reg updates when MEM_busy=0: data = load result or EX/MEM alu_res; rd, vld copied;
//   wb_en = wb_en & vld & ~err. Bubble -> vld=0, wb_en=0.
// - Store: MEM_WB_vld=1, wb_en forced 0.
// - Abort: MEM_WB_err=1, vld=1, wb_en=0, data=faulting address.
// - Reset mid-access: req drops, FSM IDLE, counter 0; pending op discarded, no MEM_WB entry.
// CONFIGURATION
// - MEM_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 -> no mem_req, 1 cycle,
//   MEM_WB_err=1, wb_en=0, data=address.
// - Not defined: low address bits ignored for alignment (H uses addr[1], W uses whole word); no trap.
// TESTING
// - LW alu_res=0x100, ack 2 cycles later, rdata=0xDEADBEEF -> busy 2 cycles, MEM_WB_data=0xDEADBEEF, wb_en=1.
// - LB addr=0x103, rdata=0x80112233 -> MEM_WB_data=0xFFFFFF80; LBU same -> 0x00000080.
// - SH addr=0x102, din=0x0000ABCD, ack w/ req -> be=1100, wdata=0xABCDABCD, no stall, wb_en=0.
// - ADD res=0x55 -> MEM_data=0x55 next cycle, no req, MEM_WB_data=0x55 one cycle later.
// - LW, ack never -> busy MEM_TIMEOUT cycles, req drops, MEM_WB_err=1, data=addr, wb_en=0.
// - LW addr=0x102: with MEM_MISALIGN_TRAP_EN err=1, no req; without -> mem_addr=0x100, normal load.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory req/ack sequencer with timeout, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W accesses raise an error instead of issuing a request.
module mem_stage #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_alu_res,
    input  logic [31:0] EX_mem_din,
    input  logic        EX_vld,
    input  logic [4:0]  EX_mem_ctrl,
    input  logic [4:0]  EX_rd,
    input  logic        EX_wb_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] MEM_data,
    output logic        MEM_busy,
    output logic [31:0] MEM_WB_data,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_wb_en,
    output logic        MEM_WB_vld,
    output logic        MEM_WB_err
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

    logic        exm_vld_q;
    logic [31:0] exm_alu_q;
    logic [31:0] exm_din_q;
    logic [4:0]  exm_ctrl_q;
    logic [4:0]  exm_rd_q;
    logic        exm_wb_en_q;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        is_load, is_store, is_unsigned;
    logic [1:0]  size, lane;
    logic        misalign, mem_op, start, abort;
    logic [3:0]  be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        wb_err;

    // Load wins when both load and store are requested.
    assign is_load     = exm_ctrl_q[4];
    assign is_store    = exm_ctrl_q[3] & ~exm_ctrl_q[4];
    assign is_unsigned = exm_ctrl_q[2];
    assign size        = exm_ctrl_q[1:0];
    assign lane        = exm_alu_q[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ((size == 2'b01) & lane[0]) | (size[1] & (lane != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign mem_op = exm_vld_q & (is_load | is_store);
    assign start  = mem_op & ~misalign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exm_vld_q   <= 1'b0;
            exm_alu_q   <= 32'd0;
            exm_din_q   <= 32'd0;
            exm_ctrl_q  <= 5'd0;
            exm_rd_q    <= 5'd0;
            exm_wb_en_q <= 1'b0;
        end else if (!MEM_busy) begin
            exm_vld_q   <= EX_vld;
            exm_alu_q   <= EX_alu_res;
            exm_din_q   <= EX_mem_din;
            exm_ctrl_q  <= EX_mem_ctrl;
            exm_rd_q    <= EX_rd;
            exm_wb_en_q <= EX_wb_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter holds the number of req-without-ack cycles seen so far for this access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_req = 1'b0;
        abort   = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                if (start) begin
                    mem_req = 1'b1;
                    if (!mem_ack) begin
                        state_d = StAccess;
                        cnt_d   = 8'd1;
                    end
                end
            end
            StAccess: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else if (cnt_q == TimeoutCnt) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    assign MEM_busy = mem_req & ~mem_ack & ~abort;
    assign MEM_data = exm_alu_q;

    always_comb begin
        be        = 4'b1111;
        mem_wdata = exm_din_q;
        case (size)
            2'b00: begin
                be        = 4'b0001 << lane;
                mem_wdata = {4{exm_din_q[7:0]}};
            end
            2'b01: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{exm_din_q[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                mem_wdata = exm_din_q;
            end
        endcase
    end

    assign mem_we   = mem_req & is_store;
    assign mem_be   = mem_req ? be : 4'b0000;
    assign mem_addr = {exm_alu_q[31:2], 2'b00};

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (lane)
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
    end

    assign ld_half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_val = mem_rdata;
        case (size)
            2'b00:   ld_val = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{~is_unsigned & ld_half[15]}}, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    assign wb_err = abort | (mem_op & misalign);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MEM_WB_data  <= 32'd0;
            MEM_WB_rd    <= 5'd0;
            MEM_WB_wb_en <= 1'b0;
            MEM_WB_vld   <= 1'b0;
            MEM_WB_err   <= 1'b0;
        end else if (!MEM_busy) begin
            MEM_WB_data  <= (exm_vld_q & is_load & ~wb_err) ? ld_val : exm_alu_q;
            MEM_WB_rd    <= exm_rd_q;
            MEM_WB_wb_en <= exm_wb_en_q & exm_vld_q & ~wb_err & ~is_store;
            MEM_WB_vld   <= exm_vld_q;
            MEM_WB_err   <= wb_err;
        end
    end

endmodule
